// File: rtl/axi_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite register file: response codes,
// write/read FSM states and the nibble-to-7-segment table.
package axi_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/axi_lite_regfile_hex7seg.sv
// Combinational nibble-to-7-segment decoder for the optional display tap
// (instantiated by axi_lite_regfile only when AXI_REGFILE_HEX_EN is defined).
module hex7seg
  import axi_regfile_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte strobes and OKAY/SLVERR responses.
// Define AXI_REGFILE_HEX_EN to add the disp_hex_r tap showing the last read nibble.
module axi_lite_regfile
  import axi_regfile_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp
`ifdef AXI_REGFILE_HEX_EN
  ,
  output logic [7:0]          disp_hex_r
`endif
);

  localparam int NB = DATA_W / 8;

  function automatic logic mapped(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                               input logic [DATA_W-1:0] new_v,
                                               input logic [NB-1:0]     strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  wstate_e           w_state_q, w_state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_strb;

  rstate_e           r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;

  // Readies are registered from the next state so they are zero during reset
  // and never see an input valid combinationally.
  assign aw_hs = s_awvalid && awready_q;
  assign w_hs  = s_wvalid && wready_q;
  assign ar_hs = s_arvalid && arready_q;

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    wr_addr   = awaddr_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en     = 1'b1;
          wr_addr   = s_awaddr;
          wr_data   = s_wdata;
          wr_strb   = s_wstrb;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          awaddr_d  = s_awaddr;
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d   = s_wdata;
          wstrb_d   = s_wstrb;
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          wr_en     = 1'b1;
          wr_data   = s_wdata;
          wr_strb   = s_wstrb;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          wr_en     = 1'b1;
          wr_addr   = s_awaddr;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (wr_en) bresp_d = mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (mapped(s_araddr)) begin
            rdata_d = mem_q[s_araddr];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Array update uses NBA, so a same-edge read still captures the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en && mapped(wr_addr)) begin
      mem_q[wr_addr] <= merge(mem_q[wr_addr], wr_data, wr_strb);
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = (r_state_q == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

`ifdef AXI_REGFILE_HEX_EN
  logic [4:0] hex_q;
  logic [6:0] seg;

  always_ff @(posedge clk) begin
    if (reset) hex_q <= '0;
    else if (s_rvalid && s_rready) hex_q <= {rresp_q[1], rdata_q[3:0]};
  end

  hex7seg u_hex7seg (
    .nib_i (hex_q[3:0]),
    .seg_o (seg)
  );

  assign disp_hex_r = {hex_q[4], seg};
`endif

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed plus random bench for axi_lite_regfile (DATA_W=16, DEPTH=12),
// checked against an array model of the register contents.
module tb_axi_lite_regfile;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_awvalid, s_awready;
  logic [3:0]  s_awaddr;
  logic        s_wvalid, s_wready;
  logic [15:0] s_wdata;
  logic [1:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [3:0]  s_araddr;
  logic        s_rvalid, s_rready;
  logic [15:0] s_rdata;
  logic [1:0]  s_rresp;
`ifdef AXI_REGFILE_HEX_EN
  logic [7:0]  disp_hex_r;
  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] ref_mem [16];

  always #5 clk = ~clk;

  axi_lite_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp)
`ifdef AXI_REGFILE_HEX_EN
    ,
    .disp_hex_r(disp_hex_r)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a write lands only on mapped words, byte by byte.
  function automatic logic [1:0] model_write(input logic [3:0] a, input logic [15:0] d,
                                             input logic [1:0] s);
    if (int'(a) >= DEPTH) return 2'b10;
    if (s[0]) ref_mem[a][7:0]  = d[7:0];
    if (s[1]) ref_mem[a][15:8] = d[15:8];
    return 2'b00;
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
  endtask

  task automatic hs_loop;
    bit aw_hs, w_hs;
    int k = 0;
    while ((s_awvalid || s_wvalid) && k < 20) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      tick();
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs)  s_wvalid  = 1'b0;
      k++;
    end
    chk("aw_w_accepted", 16'({s_awvalid, s_wvalid}), 16'h0);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s,
                           input int mode);
    logic [1:0] er;
    er = model_write(a, d, s);
    s_awaddr = a;
    s_wdata  = d;
    s_wstrb  = s;
    case (mode)
      1: begin
        s_wvalid = 1'b1;
        hs_loop();
        repeat (3) begin
          chk("wait_awready", 16'(s_awready), 16'h1);
          chk("wait_wready", 16'(s_wready), 16'h0);
          tick();
        end
        s_awvalid = 1'b1;
        hs_loop();
      end
      2: begin
        s_awvalid = 1'b1;
        hs_loop();
        chk("have_a_awready", 16'(s_awready), 16'h0);
        tick();
        tick();
        s_wvalid = 1'b1;
        hs_loop();
      end
      default: begin
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        hs_loop();
      end
    endcase
    chk("bvalid", 16'(s_bvalid), 16'h1);
    chk("bresp", 16'(s_bresp), 16'(er));
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("bvalid_clr", 16'(s_bvalid), 16'h0);
  endtask

  task automatic axi_read(input logic [3:0] a);
    logic [15:0] ed;
    logic [1:0]  er;
    bit hs;
    int k = 0;
    if (int'(a) < DEPTH) begin
      ed = ref_mem[a];
      er = 2'b00;
    end else begin
      ed = 16'h0;
      er = 2'b10;
    end
    s_araddr  = a;
    s_arvalid = 1'b1;
    while (s_arvalid && k < 20) begin
      hs = s_arvalid && s_arready;
      tick();
      if (hs) s_arvalid = 1'b0;
      k++;
    end
    chk("ar_accepted", 16'(s_arvalid), 16'h0);
    s_arvalid = 1'b0;
    chk("rvalid", 16'(s_rvalid), 16'h1);
    chk("rdata", s_rdata, ed);
    chk("rresp", 16'(s_rresp), 16'(er));
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk("rvalid_clr", 16'(s_rvalid), 16'h0);
`ifdef AXI_REGFILE_HEX_EN
    chk("hex", 16'(disp_hex_r), 16'({er[1], SEG[ed[3:0]]}));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 16'(s_awready), 16'h0);
    chk({tag, "_wready"}, 16'(s_wready), 16'h0);
    chk({tag, "_arready"}, 16'(s_arready), 16'h0);
    chk({tag, "_bvalid"}, 16'(s_bvalid), 16'h0);
    chk({tag, "_bresp"}, 16'(s_bresp), 16'h0);
    chk({tag, "_rvalid"}, 16'(s_rvalid), 16'h0);
    chk({tag, "_rdata"}, s_rdata, 16'h0);
    chk({tag, "_rresp"}, 16'(s_rresp), 16'h0);
  endtask

  initial begin
    logic [15:0] old_v;
    logic [1:0]  er;
    reset = 1'b1;
    s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;
    model_clear();
    repeat (3) tick();
    chk_all_zero("reset");
`ifdef AXI_REGFILE_HEX_EN
    chk("hex_reset", 16'(disp_hex_r), 16'h3F);
`endif
    reset = 1'b0;

    // Same-cycle AW+W, then read back.
    axi_write(4'd3, 16'h00A5, 2'b01, 0);
    axi_read(4'd3);

    // W first, AW three cycles later.
    axi_write(4'd5, 16'h003C, 2'b01, 1);
    axi_read(4'd5);

    // Byte strobes: upper byte only on the second write.
    axi_write(4'd2, 16'h1234, 2'b11, 2);
    axi_write(4'd2, 16'hFF00, 2'b10, 0);
    axi_read(4'd2);
    chk("strb_merge", ref_mem[2], 16'hFF34);

    // Unmapped addresses.
    axi_write(4'd13, 16'hDEAD, 2'b11, 0);
    axi_read(4'd15);
    axi_read(4'd3);

    // Backpressure on both response channels.
    chk("bp_awready", 16'(s_awready), 16'h1);
    chk("bp_arready", 16'(s_arready), 16'h1);
    er = model_write(4'd6, 16'hBEEF, 2'b11);
    s_awaddr = 4'd6; s_wdata = 16'hBEEF; s_wstrb = 2'b11; s_araddr = 4'd2;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    repeat (4) begin
      chk("bp_bvalid", 16'(s_bvalid), 16'h1);
      chk("bp_bresp", 16'(s_bresp), 16'(er));
      chk("bp_rvalid", 16'(s_rvalid), 16'h1);
      chk("bp_rdata", s_rdata, ref_mem[2]);
      chk("bp_readies", 16'({s_awready, s_wready, s_arready}), 16'h0);
      tick();
    end
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    chk("bp_release", 16'({s_bvalid, s_rvalid}), 16'h0);
    axi_read(4'd6);

    // Same-edge write commit and read of one address returns the old value.
    axi_write(4'd1, 16'h0011, 2'b11, 0);
    old_v = ref_mem[1];
    er = model_write(4'd1, 16'h0077, 2'b11);
    s_awaddr = 4'd1; s_wdata = 16'h0077; s_wstrb = 2'b11; s_araddr = 4'd1;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("coll_rvalid", 16'(s_rvalid), 16'h1);
    chk("coll_rdata", s_rdata, old_v);
    chk("coll_bvalid", 16'(s_bvalid), 16'h1);
    chk("coll_bresp", 16'(s_bresp), 16'(er));
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    axi_read(4'd1);

    // Reset while holding an address only: everything clears.
    axi_write(4'd4, 16'hABCD, 2'b11, 0);
    s_awaddr = 4'd4; s_awvalid = 1'b1;
    chk("mid_awready", 16'(s_awready), 16'h1);
    tick();
    s_awvalid = 1'b0;
    chk("have_a_ready", 16'({s_awready, s_wready}), 16'h1);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    model_clear();
    tick();
    axi_read(4'd4);
    axi_read(4'd2);

    // Random mix of reads and writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
      else
        axi_read(4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
